// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles MSB-first framed words and hands
// them off through a single-entry valid/ready holding register.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word;
  logic             restart;
  logic             complete;

  assign word     = {sreg[WIDTH-2:0], sin};
  assign restart  = sin_en & sof;
  // sof always starts a word, so it can never be the completing strobe
  assign complete = sin_en & ~sof & (state == SHIFT) & (cnt == CW'(WIDTH - 1));
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (restart) begin
        sreg      <= {{(WIDTH-1){1'b0}}, sin};
        cnt       <= CW'(1);
        state     <= SHIFT;
        frame_err <= (state == SHIFT);
      end else if (sin_en && state == SHIFT) begin
        sreg <= word;
        if (complete) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Holding register: a completion while the consumer stalls is dropped,
  // never overwriting the word it has not yet taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!dout_valid || dout_ready) begin
          dout       <= word;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: a WIDTH=4 instance for the main scenarios and a
// WIDTH=8 instance for back-to-back wide words.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       sin = 1'b0, sin_en = 1'b0, sof = 1'b0, dout_ready = 1'b0;
  logic [3:0] dout;
  logic       dout_valid, busy, overrun, frame_err;

  logic       sin8 = 1'b0, sin_en8 = 1'b0, sof8 = 1'b0, ready8 = 1'b0;
  logic [7:0] dout8;
  logic       valid8, busy8, ovr8, fe8;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0, fe_cnt = 0, ov8_cnt = 0, fe8_cnt = 0;
  int base_ov, base_fe;

  sipo_rx #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  sipo_rx #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .sin(sin8), .sin_en(sin_en8), .sof(sof8),
    .dout(dout8), .dout_valid(valid8), .dout_ready(ready8),
    .busy(busy8), .overrun(ovr8), .frame_err(fe8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (overrun)   ov_cnt++;
    if (frame_err) fe_cnt++;
    if (ovr8)      ov8_cnt++;
    if (fe8)       fe8_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic f, input logic b);
    sof    = f;
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic send8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      sof8    = (i == 7);
      sin8    = w[i];
      sin_en8 = 1'b1;
      tick();
    end
    sin_en8 = 1'b0;
    sof8    = 1'b0;
  endtask

  initial begin
    // reset asserted asynchronously before any clock edge
    #1 rst = 1'b0;
    #2;
    chk("rst_dout",   32'(dout), 0);
    chk("rst_valid",  32'(dout_valid), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_ovr",    32'(overrun), 0);
    chk("rst_fe",     32'(frame_err), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // basic word 1011
    dout_ready = 1'b1;
    send(1, 1);
    chk("basic_busy1", 32'(busy), 1);
    send(0, 0);
    chk("basic_busy2", 32'(busy), 1);
    send(0, 1);
    chk("basic_busy3", 32'(busy), 1);
    chk("basic_valid_early", 32'(dout_valid), 0);
    send(0, 1);
    chk("basic_dout",  32'(dout), 32'hB);
    chk("basic_valid", 32'(dout_valid), 1);
    chk("basic_busy4", 32'(busy), 0);
    tick();
    chk("basic_valid_clr", 32'(dout_valid), 0);
    chk("basic_dout_hold", 32'(dout), 32'hB);

    // gapped strobes
    base_ov = ov_cnt;
    base_fe = fe_cnt;
    send(1, 1); repeat (3) tick();
    send(0, 0); repeat (3) tick();
    send(0, 1); repeat (3) tick();
    chk("gap_busy", 32'(busy), 1);
    send(0, 1);
    chk("gap_dout",  32'(dout), 32'hB);
    chk("gap_valid", 32'(dout_valid), 1);
    tick();
    chk("gap_fe",  32'(fe_cnt - base_fe), 0);
    chk("gap_ovr", 32'(ov_cnt - base_ov), 0);

    // backpressure with overrun
    dout_ready = 1'b0;
    base_ov = ov_cnt;
    send(1, 1); send(0, 0); send(0, 1); send(0, 1);
    chk("bp_first", 32'(dout), 32'hB);
    send(1, 0); send(0, 1); send(0, 1); send(0, 0);
    chk("bp_ovr_pulse", 32'(overrun), 1);
    chk("bp_dout",  32'(dout), 32'hB);
    chk("bp_valid", 32'(dout_valid), 1);
    tick();
    chk("bp_ovr_clr", 32'(overrun), 0);
    chk("bp_ovr_cnt", 32'(ov_cnt - base_ov), 1);
    dout_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(dout_valid), 0);

    // ready on the completion edge replaces the word
    dout_ready = 1'b0;
    base_ov = ov_cnt;
    send(1, 1); send(0, 0); send(0, 1); send(0, 1);
    send(1, 0); send(0, 1); send(0, 1);
    dout_ready = 1'b1;
    send(0, 0);
    chk("rep_dout",  32'(dout), 32'h6);
    chk("rep_valid", 32'(dout_valid), 1);
    tick();
    chk("rep_ovr", 32'(ov_cnt - base_ov), 0);
    chk("rep_valid_clr", 32'(dout_valid), 0);

    // framing error: sof,1,1 then sof,0,0,1,1
    base_fe = fe_cnt;
    send(1, 1); send(0, 1);
    send(1, 0);
    chk("fe_pulse", 32'(frame_err), 1);
    chk("fe_busy",  32'(busy), 1);
    send(0, 0); send(0, 1); send(0, 1);
    chk("fe_dout",  32'(dout), 32'h3);
    chk("fe_valid", 32'(dout_valid), 1);
    tick();
    chk("fe_cnt", 32'(fe_cnt - base_fe), 1);

    // strobes without sof in IDLE do nothing
    send(0, 1); send(0, 0); send(0, 1); send(0, 1);
    chk("idle_busy",  32'(busy), 0);
    chk("idle_valid", 32'(dout_valid), 0);
    chk("idle_dout",  32'(dout), 32'h3);

    // async reset mid-word with a word pending
    dout_ready = 1'b0;
    send(1, 1); send(0, 0); send(0, 1); send(0, 1);
    send(1, 1); send(0, 0);
    chk("pre_rst_valid", 32'(dout_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout",  32'(dout), 0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_err",   32'({overrun, frame_err}), 0);
    rst = 1'b1;
    tick();
    dout_ready = 1'b1;
    base_ov = ov_cnt;
    base_fe = fe_cnt;
    send(1, 1); send(0, 0); send(0, 1); send(0, 1);
    chk("post_rst_dout",  32'(dout), 32'hB);
    chk("post_rst_valid", 32'(dout_valid), 1);
    tick();
    chk("post_rst_errs", 32'((ov_cnt - base_ov) + (fe_cnt - base_fe)), 0);

    // WIDTH=8 back-to-back words
    ready8 = 1'b1;
    sin_en8 = 1'b0;
    send8(8'hA5);
    chk("w8_first",       32'(dout8), 32'hA5);
    chk("w8_first_valid", 32'(valid8), 1);
    chk("w8_first_busy",  32'(busy8), 0);
    send8(8'h3C);
    chk("w8_second",       32'(dout8), 32'h3C);
    chk("w8_second_valid", 32'(valid8), 1);
    tick();
    chk("w8_errs", 32'(ov8_cnt + fe8_cnt), 0);
    chk("w8_valid_clr", 32'(valid8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver: the receiving end of the PISO serial link. It samples a framed serial bit stream MSB-first, reassembles WIDTH-bit words, and presents each completed word on a parallel output with a valid/ready handshake. A single-entry output holding register lets the shifter capture the next word while the consumer stalls. Overrun and framing errors are flagged.

## Interface
- WIDTH, 4: word width in bits; at least 2.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-low reset.
- sin  in  1  serial data bit.
- sin_en  in  1  bit strobe; sin is sampled only on edges where sin_en=1.
- sof  in  1  start-of-frame; qualifies the current strobed bit as bit 0 (the MSB) of a word. Ignored when sin_en=0.
- dout  out  WIDTH  received word; MSB is the first bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout on edges where dout_valid=1.
- busy  out  1  a word is partially received (SHIFT state).
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- frame_err  out  1  one-cycle pulse: sof arrived mid-word and the partial word was discarded.

## Operation
- Reset values: dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0, bit counter=0, shift register=0, state=IDLE.
- States:
  - IDLE: a strobe with sin_en=1 and sof=0 is ignored. A strobe with sin_en=1 and sof=1 shifts sin in, sets the counter to 1, and moves to SHIFT.
  - SHIFT, strobe with sof=0: shift left, inserting sin at the LSB, and increment the counter.
  - SHIFT, strobe with sof=1: discard the partial word, pulse frame_err, treat sin as bit 0 of a new word, and set the counter to 1. The state stays SHIFT.
  - SHIFT, no strobe: hold the shift register and counter. There is no timeout.
- Word completion: the strobe that brings the count to WIDTH completes the word, shifted value included. State returns to IDLE and the counter resets to 0. A new sof is required for every word.
  - WIDTH=1 is not supported.
- Output holding register, evaluated at each completion edge:
  - dout_valid=0: load dout and set dout_valid=1.
  - dout_valid=1 and dout_ready=1: the old word is consumed this edge. Load the new word; dout_valid stays 1.
  - dout_valid=1 and dout_ready=0: drop the new word, pulse overrun, and leave dout unchanged.
- Handshake: a transfer occurs on an edge with dout_valid=1 and dout_ready=1. With no completion on that edge, dout_valid clears and dout holds its last value. dout is stable whenever dout_valid=1 and dout_ready=0.
- busy=1 exactly while the state is SHIFT.
- Asynchronous reset asserted mid-word or with a word pending clears everything immediately. The partial or pending word is lost and no error pulse is generated.

## Timing
- Every output is registered. Inputs are sampled only on the rising edge of clk.
- Latency: dout and dout_valid update on the same edge that samples the last bit. With back-to-back strobes, that is WIDTH edges after the sof edge, counting the sof edge as edge 1.
- Throughput: one word per WIDTH strobes, sustained with dout_ready held at 1. Back-to-back frames are allowed: the strobe after a completion may carry sof.
- overrun and frame_err are high for exactly one cycle, in the cycle after the causing edge.
- dout_ready has no combinational path to any output.

## Test plan
- Basic, WIDTH=4:
  - Stimulus: after reset release, strobe 1,0,1,1 on consecutive edges with sof on the first; dout_ready=1.
  - Required: dout=4'b1011 and dout_valid=1 right after the 4th edge; busy is 1 for edges 1-3 and 0 after edge 4; dout_valid clears one edge later.
- Gapped strobes:
  - Stimulus: same word with sin_en low for 3 cycles between each bit.
  - Required: dout=4'b1011 after the 4th strobe; no error pulses.
- Backpressure and overrun:
  - Stimulus: dout_ready=0; send 1011 then 0110.
  - Required: dout stays 1011 with dout_valid=1, and overrun pulses once at completion of 0110. Then raise dout_ready: dout_valid clears.
  - Repeat with dout_ready=1 on the 0110 completion edge: dout becomes 0110, dout_valid stays 1, no overrun.
- Framing error:
  - Stimulus: sof, 1, 1; then sof with bits 0,0,1,1.
  - Required: frame_err pulses once; dout=4'b0011.
  - Also: strobes without sof in IDLE produce no output and busy=0.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between clock edges after 2 bits of a word, with a word pending on dout.
  - Required: all outputs go to 0 immediately. After release, a fresh 1011 frame is received correctly.
- Parameter sweep:
  - Stimulus: WIDTH=8 with pattern 8'hA5 MSB-first, then 8'h3C back-to-back.
  - Required: both words delivered in order with dout_ready=1 and no gaps or errors.
